y_mc_ctrl: RTL
==============

# y_mc_ctrl

Multi-cycle control sequencer that owns the program counter and drives the existing fetch/decode/execute/memory/write-back datapath stages. It replaces per-instruction control set by the bench. It latches each fetched instruction, decodes it, and steps through per-class states. It emits one-cycle write strobes and computes the next PC, including beq and j. It sits upstream of the datapath: its `pc` feeds the fetch stage's PCin, and its `ir` and control outputs feed the decode, execute, data-memory and write-back stages.

## Interface
- RESET_PC, 128: PC value loaded on reset.
- MAX_INSTR, 0: retire limit; 0 = unlimited, else enter HALT after this many retirements.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- ins  in  32  instruction from fetch stage at address `pc`.
- imm  in  32  sign-extended immediate from decode stage, computed from `ir`.
- zero  in  1  ALU zero flag from execute stage.
- pc  out  32  current instruction address.
- ir  out  32  latched instruction.
- RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out  1 each  datapath controls.
- op  out  3  ALU operation.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- icount  out  32  retired-instruction count.
- halted  out  1  high in HALT.
- bad_op  out  1  sticky; set on an unsupported opcode or funct.

## Operation
- Reset (async, rst_n=0) forces:
  - pc=RESET_PC, ir=0, state=FETCH, icount=0, halted=0, bad_op=0.
  - All strobes 0, RegDst=0, ALUSrc=1, op=010.
- FETCH: ir <= ins; next state DECODE.
- DECODE: classify ir[31:26]; the funct field is ir[5:0].
  - R (opcode 0x00), with RegDst=1, ALUSrc=0, path E->WB, by funct:
    - 0x20 add: op=010.
    - 0x22 sub: op=110.
    - 0x24 and: op=000.
    - 0x25 or: op=001.
    - 0x2a slt: op=111.
  - addi (0x08): ALUSrc=1, op=010, path E->WB.
  - lw (0x23): ALUSrc=1, op=010, Mem2Reg=1, path E->MEM->WB.
  - sw (0x2b): ALUSrc=1, op=010, path E->MEM.
  - beq (0x04): ALUSrc=0, op=110, path E.
  - j (0x02): path E.
  - Any other opcode, or any other R-type funct: bad_op<=1, next state HALT; pc and icount unchanged.
- RegDst, ALUSrc, op and Mem2Reg are decoded combinationally from registered `state` and `ir`. They are stable from DECODE through the last state. In FETCH and HALT they take reset defaults.
- MemRead=1 in MEM and WB for lw only.
- MemWrite=1 in MEM for sw only; it is a single-cycle pulse.
- RegWrite=1 in WB only; it is a single-cycle pulse.
- Next PC is registered on the edge leaving the instruction's last state. pc4 = pc+4, mod 2^32.
  - beq: pc <= zero ? pc4+(imm<<2) : pc4, with zero sampled on the EXEC edge and 32-bit wrap.
  - j: pc <= {pc4[31:28], ir[25:0], 2'b00}.
  - All others: pc <= pc4.
- Retire: on the same edge, icount <= icount+1 (wraps).
  - If MAX_INSTR≠0 and the new icount == MAX_INSTR, next state is HALT; otherwise FETCH.
- HALT is sticky until reset: pc, ir and icount are frozen; halted=1; all strobes 0.

## Timing
- Cycles per instruction: j and beq 3; R, addi and sw 4; lw 5.
- `ins` is sampled only on the FETCH edge; changes on `ins` at any other time are ignored.
- `zero` is sampled only on the beq EXEC edge. `imm` is used only on that same edge.
- Reset asserted mid-instruction:
  - Strobes drop immediately (combinational from the async-cleared state).
  - No partial write occurs; pc returns to RESET_PC.
- First FETCH after rst_n deasserts begins on the first rising edge with rst_n=1.
- Retire edge with MAX_INSTR reached and pc update coincide: pc is still updated, then HALT.

## Test plan
- Reset: rst_n low mid-WB of an add.
  - RegWrite falls without a clock edge.
  - After release: pc=128, state=0, icount=0.
- add at 128 (0x01095020), then or at 132 (0x01095025):
  - op=010 then 001.
  - RegWrite pulses exactly once per instruction, in cycles 4 and 8.
  - pc=136 and icount=2 after 8 cycles.
- lw (0x8d090004) then sw (0xad090008):
  - lw: MemRead high for 2 cycles, Mem2Reg=1, RegWrite pulses in cycle 5.
  - sw: MemWrite pulses for 1 cycle, RegWrite never asserted.
  - Total 9 cycles.
- beq at 140 with imm=3:
  - zero=1 gives pc=156.
  - zero=0 gives pc=144.
  - 3 cycles each; imm=-1 (0xffffffff) with zero=1 gives pc=140.
- j at 160, ins=0x08000020: pc=0x00000080 after 3 cycles.
- Illegal opcode 0x3f at pc=200:
  - bad_op=1 and halted=1 after DECODE.
  - pc=200 and icount unchanged; no strobes asserted.
- MAX_INSTR=2, two addi instructions: after the second retire, halted=1, icount=2, pc=136.

Source files
------------

// File: rtl/y_mc_ctrl.sv
// Multi-cycle control sequencer: owns the PC, latches and decodes instructions,
// and walks FETCH/DECODE/EXEC/MEM/WB to drive the datapath stages.
module y_mc_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'd128,
   parameter logic [31:0] MAX_INSTR = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ins,
   input  logic [31:0] imm,
   input  logic        zero,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrc,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Mem2Reg,
   output logic [2:0]  op,
   output logic [2:0]  state,
   output logic [31:0] icount,
   output logic        halted,
   output logic        bad_op
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_R,
      C_ADDI,
      C_LW,
      C_SW,
      C_BEQ,
      C_J,
      C_BAD
   } class_t;

   state_t      cur_state;
   state_t      next_state;
   class_t      cls;
   logic [2:0]  r_op;
   logic        active;
   logic        retire;
   logic        bad_hit;
   logic [31:0] pc4;
   logic [31:0] br_tgt;
   logic [31:0] next_pc;
   logic [31:0] icount_inc;

   // Instruction class and R-type ALU op come straight from the latched ir.
   always_comb begin
      cls  = C_BAD;
      r_op = 3'b010;
      case (ir[31:26])
         6'h00: begin
            case (ir[5:0])
               6'h20: begin cls = C_R; r_op = 3'b010; end
               6'h22: begin cls = C_R; r_op = 3'b110; end
               6'h24: begin cls = C_R; r_op = 3'b000; end
               6'h25: begin cls = C_R; r_op = 3'b001; end
               6'h2a: begin cls = C_R; r_op = 3'b111; end
               default: cls = C_BAD;
            endcase
         end
         6'h08:   cls = C_ADDI;
         6'h23:   cls = C_LW;
         6'h2b:   cls = C_SW;
         6'h04:   cls = C_BEQ;
         6'h02:   cls = C_J;
         default: cls = C_BAD;
      endcase
   end

   // Datapath controls hold reset defaults in FETCH, HALT and for illegal encodings.
   always_comb begin
      RegDst   = 1'b0;
      ALUSrc   = 1'b1;
      op       = 3'b010;
      Mem2Reg  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      active   = (cur_state == S_DECODE || cur_state == S_EXEC ||
                  cur_state == S_MEM    || cur_state == S_WB) && (cls != C_BAD);
      if (active) begin
         case (cls)
            C_R: begin
               RegDst = 1'b1;
               ALUSrc = 1'b0;
               op     = r_op;
            end
            C_LW:    Mem2Reg = 1'b1;
            C_BEQ: begin
               ALUSrc = 1'b0;
               op     = 3'b110;
            end
            default: ;
         endcase
         MemRead  = (cur_state == S_MEM || cur_state == S_WB) && (cls == C_LW);
         MemWrite = (cur_state == S_MEM) && (cls == C_SW);
         RegWrite = (cur_state == S_WB);
      end
   end

   assign pc4        = pc + 32'd4;
   assign br_tgt     = pc4 + (imm << 2);
   assign icount_inc = icount + 32'd1;

   always_comb begin
      case (cls)
         C_BEQ:   next_pc = zero ? br_tgt : pc4;
         C_J:     next_pc = {pc4[31:28], ir[25:0], 2'b00};
         default: next_pc = pc4;
      endcase
   end

   // Retirement happens on the edge leaving each class's final state.
   always_comb begin
      next_state = cur_state;
      retire     = 1'b0;
      bad_hit    = 1'b0;
      case (cur_state)
         S_FETCH: next_state = S_DECODE;
         S_DECODE: begin
            if (cls == C_BAD) begin
               next_state = S_HALT;
               bad_hit    = 1'b1;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls)
               C_BEQ, C_J: retire     = 1'b1;
               C_LW, C_SW: next_state = S_MEM;
               default:    next_state = S_WB;
            endcase
         end
         S_MEM: begin
            if (cls == C_LW) next_state = S_WB;
            else             retire     = 1'b1;
         end
         S_WB:    retire     = 1'b1;
         S_HALT:  next_state = S_HALT;
         default: next_state = S_FETCH;
      endcase
      if (retire) begin
         if (MAX_INSTR != 32'd0 && icount_inc == MAX_INSTR) next_state = S_HALT;
         else                                                next_state = S_FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_FETCH;
         pc        <= RESET_PC;
         ir        <= 32'd0;
         icount    <= 32'd0;
         bad_op    <= 1'b0;
      end else begin
         cur_state <= next_state;
         if (cur_state == S_FETCH) ir <= ins;
         if (retire) begin
            pc     <= next_pc;
            icount <= icount_inc;
         end
         if (bad_hit) bad_op <= 1'b1;
      end
   end

   assign state  = cur_state;
   assign halted = (cur_state == S_HALT);

endmodule
